// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the serial program loader.
// State encodings, reset levels for the CPU and frame geometry.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  function automatic logic [7:0] csum_step(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Host byte stream plus instruction-ROM write port.
// master drives bytes, slave is the loader.
interface boot_loader_if #(
  parameter int ADDR_W = 10
) ();

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  rom_we,
    input  rom_addr,
    input  rom_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output rom_we,
    output rom_addr,
    output rom_wdata
  );

endinterface

// File: rtl/boot_loader_word_packer.sv
// Packs big-endian bytes into 32-bit words.
// word/word_valid present the completed word on its 4th byte.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      sr  <= {sr[15:0], din};
      cnt <= cnt + 2'd1;
    end
  end

  assign word_valid = en && (cnt == 2'd3);
  assign word       = {sr, din};

endmodule

// File: rtl/boot_loader.sv
// Receives a length-prefixed, XOR-checked program image and
// writes it to instruction ROM, holding the CPU in reset meanwhile.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  boot_loader_if.slave bus,
  input  logic         reload,
  output logic         cpu_rst,
  output logic         done,
  output logic         err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t      state;
  state_t      nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] widx;
  logic [7:0]  csum;

  logic        xfer;
  logic        pk_en;
  logic        pk_valid;
  logic [31:0] pk_word;
  logic        in_range;
  logic        last_word;
  logic        hdr_xfer;

  assign xfer      = bus.rx_valid && bus.rx_ready;
  assign pk_en     = xfer && (state == ST_DATA);
  assign in_range  = {16'd0, widx} < DEPTH;
  assign last_word = widx == (len - 16'd1);
  assign hdr_xfer  = xfer && (state inside
                     {ST_HDR0, ST_HDR1, ST_DATA});

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .en         (pk_en),
    .din        (bus.rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_HDR0: if (xfer) nxt = ST_HDR1;
      ST_HDR1:
        if (xfer)
          nxt = ({len_hi, bus.rx_data} == 16'd0)
              ? ST_CSUM : ST_DATA;
      ST_DATA: if (pk_valid && last_word) nxt = ST_CSUM;
      ST_CSUM:
        if (xfer)
          nxt = (bus.rx_data == csum) ? ST_RUN : ST_ERROR;
      ST_RUN:  if (reload) nxt = ST_HDR0;
      default: nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_HDR0;
      len_hi        <= '0;
      len           <= '0;
      widx          <= '0;
      csum          <= '0;
      bus.rx_ready  <= 1'b0;
      bus.rom_we    <= 1'b0;
      bus.rom_addr  <= '0;
      bus.rom_wdata <= '0;
      cpu_rst       <= RST_ENABLE;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state        <= nxt;
      bus.rx_ready <= nxt inside
                      {ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM};
      done         <= nxt == ST_RUN;
      err          <= nxt == ST_ERROR;
      // release lags RUN entry by one cycle; reload reasserts at once
      cpu_rst      <= (state == ST_RUN && !reload)
                      ? RST_DISABLE : RST_ENABLE;
      bus.rom_we   <= 1'b0;
      if (hdr_xfer)
        csum <= csum_step(csum, bus.rx_data);
      if (xfer && state == ST_HDR0)
        len_hi <= bus.rx_data;
      if (xfer && state == ST_HDR1) begin
        len          <= {len_hi, bus.rx_data};
        widx         <= '0;
        bus.rom_addr <= '0;
      end
      // words beyond the ROM are consumed but never written
      if (pk_valid) begin
        widx <= widx + 16'd1;
        if (in_range) begin
          bus.rom_we    <= 1'b1;
          bus.rom_addr  <= widx[ADDR_W-1:0];
          bus.rom_wdata <= pk_word;
        end
      end
      if (state == ST_RUN && reload) begin
        csum         <= '0;
        widx         <= '0;
        bus.rom_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a write scoreboard.
// Two instances: default ROM depth and a 4-word ROM.
module tb_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(10)) ifa ();
  boot_loader_if #(.ADDR_W(2))  ifb ();

  logic reload_a = 1'b0;
  logic reload_b = 1'b0;
  logic cpu_rst_a, done_a, err_a;
  logic cpu_rst_b, done_b, err_b;

  logic       v   = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] d   = 8'h00;
  logic       rdy;

  assign ifa.rx_valid = v & ~sel;
  assign ifb.rx_valid = v & sel;
  assign ifa.rx_data  = d;
  assign ifb.rx_data  = d;
  assign rdy = sel ? ifb.rx_ready : ifa.rx_ready;

  boot_loader #(.ADDR_W(10)) u_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifa.slave),
    .reload  (reload_a),
    .cpu_rst (cpu_rst_a),
    .done    (done_a),
    .err     (err_a)
  );

  boot_loader #(.ADDR_W(2)) u_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifb.slave),
    .reload  (reload_b),
    .cpu_rst (cpu_rst_b),
    .done    (done_b),
    .err     (err_b)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int wa = 0;
  int wb = 0;

  always @(negedge clk) begin
    if (ifa.rom_we === 1'b1) begin
      wa++;
      if (qa.size() == 0)
        chk("spurious_we_a", 64'(ifa.rom_we), 64'd0);
      else
        chk("write_a", 64'({ifa.rom_addr, ifa.rom_wdata}),
            qa.pop_front());
    end
    if (ifb.rom_we === 1'b1) begin
      wb++;
      if (qb.size() == 0)
        chk("spurious_we_b", 64'(ifb.rom_we), 64'd0);
      else
        chk("write_b", 64'({ifb.rom_addr, ifb.rom_wdata}),
            qb.pop_front());
    end
  end

  task automatic send(input logic [7:0] b, input bit stall);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      t++;
      if (t > 60) begin
        chk("ready_timeout", 64'(rdy), 64'd1);
        break;
      end
      if (stall && $urandom_range(0, 2) == 0) begin
        v = 1'b0;
        d = 8'($urandom);
      end else begin
        v = 1'b1;
        d = b;
        if (rdy === 1'b1) break;
      end
    end
  endtask

  logic [31:0] words[$];

  task automatic frame(input bit s, input bit bad,
                       input bit stall, input int reload_at,
                       input int stop_at);
    logic [7:0]  bytes[$];
    logic [7:0]  c;
    logic [15:0] n16;
    int          n;
    int          depth;
    int          w;
    n     = words.size();
    n16   = 16'(n);
    depth = s ? 4 : 1024;
    c     = 8'h00;
    bytes.push_back(n16[15:8]);
    bytes.push_back(n16[7:0]);
    foreach (words[i])
      for (int k = 3; k >= 0; k--)
        bytes.push_back(words[i][8*k +: 8]);
    foreach (bytes[i]) c ^= bytes[i];
    bytes.push_back(bad ? ~c : c);
    sel = s;
    foreach (bytes[i]) begin
      if (i == stop_at) break;
      if (i == reload_at) begin
        @(negedge clk);
        v = 1'b0;
        reload_a = 1'b1;
        @(negedge clk);
        reload_a = 1'b0;
        chk("reload_in_data_cpu_rst", 64'(cpu_rst_a), 64'd1);
        chk("reload_in_data_ready", 64'(rdy), 64'd1);
      end
      if (i >= 2 && i < 2 + 4*n && (i - 2) % 4 == 3) begin
        w = (i - 2) / 4;
        if (w < depth) begin
          if (s) qb.push_back(64'({2'(w), words[w]}));
          else   qa.push_back(64'({10'(w), words[w]}));
        end
      end
      send(bytes[i], stall);
    end
    @(negedge clk);
    v = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload_a = 1'b1;
    @(negedge clk);
    reload_a = 1'b0;
    chk("reload_cpu_rst", 64'(cpu_rst_a), 64'd1);
    chk("reload_done", 64'(done_a), 64'd0);
    chk("reload_ready", 64'(ifa.rx_ready), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(ifa.rx_ready), 64'd0);
    chk({tag, "_we"}, 64'(ifa.rom_we), 64'd0);
    chk({tag, "_addr"}, 64'(ifa.rom_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(ifa.rom_wdata), 64'd0);
    chk({tag, "_cpu_rst"}, 64'(cpu_rst_a), 64'd1);
    chk({tag, "_done"}, 64'(done_a), 64'd0);
    chk({tag, "_err"}, 64'(err_a), 64'd0);
  endtask

  int w0;

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    chk("ready_before_edge", 64'(ifa.rx_ready), 64'd0);
    @(negedge clk);
    chk("ready_first_edge", 64'(ifa.rx_ready), 64'd1);

    // N=2 good frame
    w0 = wa;
    words = '{32'h3C010101, 32'h34210020};
    frame(1'b0, 1'b0, 1'b0, -1, -1);
    chk("n2_done", 64'(done_a), 64'd1);
    chk("n2_cpu_rst_entry", 64'(cpu_rst_a), 64'd1);
    chk("n2_ready_run", 64'(ifa.rx_ready), 64'd0);
    @(negedge clk);
    chk("n2_cpu_rst_after", 64'(cpu_rst_a), 64'd0);
    chk("n2_done_hold", 64'(done_a), 64'd1);
    chk("n2_writes", 64'(wa - w0), 64'd2);

    // reload, new frame with stalls and a reload pulse in DATA
    do_reload();
    w0 = wa;
    words = '{32'hDEADBEEF, 32'h01234567, 32'hA5A55A5A};
    frame(1'b0, 1'b0, 1'b1, 7, -1);
    chk("n3_done", 64'(done_a), 64'd1);
    chk("n3_writes", 64'(wa - w0), 64'd3);

    // reset mid-DATA, then a full frame
    do_reload();
    w0 = wa;
    words = '{32'h11223344, 32'h55667788,
              32'h99AABBCC, 32'hDDEEFF00};
    frame(1'b0, 1'b0, 1'b1, -1, 9);
    chk("partial_writes", 64'(wa - w0), 64'd1);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    w0 = wa;
    words = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678};
    frame(1'b0, 1'b0, 1'b1, -1, -1);
    chk("after_rst_done", 64'(done_a), 64'd1);
    chk("after_rst_writes", 64'(wa - w0), 64'd3);

    // N=0
    do_reload();
    w0 = wa;
    words.delete();
    frame(1'b0, 1'b0, 1'b0, -1, -1);
    chk("n0_done", 64'(done_a), 64'd1);
    chk("n0_writes", 64'(wa - w0), 64'd0);

    // bad checksum
    do_reload();
    w0 = wa;
    words = '{32'h00000013};
    frame(1'b0, 1'b1, 1'b0, -1, -1);
    chk("bad_err", 64'(err_a), 64'd1);
    chk("bad_done", 64'(done_a), 64'd0);
    chk("bad_cpu_rst", 64'(cpu_rst_a), 64'd1);
    chk("bad_ready", 64'(ifa.rx_ready), 64'd0);
    chk("bad_writes", 64'(wa - w0), 64'd1);
    @(negedge clk);
    reload_a = 1'b1;
    @(negedge clk);
    reload_a = 1'b0;
    @(negedge clk);
    chk("err_sticky", 64'(err_a), 64'd1);
    chk("err_ready", 64'(ifa.rx_ready), 64'd0);
    chk("err_cpu_rst", 64'(cpu_rst_a), 64'd1);
    rst = 1'b0;
    #1;
    chk("err_cleared", 64'(err_a), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 4-word ROM, 5-word frame
    w0 = wb;
    words = '{32'h10000001, 32'h20000002, 32'h30000003,
              32'h40000004, 32'h50000005};
    frame(1'b1, 1'b0, 1'b1, -1, -1);
    chk("small_done", 64'(done_b), 64'd1);
    chk("small_err", 64'(err_b), 64'd0);
    chk("small_writes", 64'(wb - w0), 64'd4);
    sel = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_a_empty", 64'(qa.size()), 64'd0);
    chk("queue_b_empty", 64'(qb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
